// File: rtl/adc_arb_pkg.sv
// Shared definitions for the column-ADC arbiter: FSM state type and
// default sizing constants.
package adc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_CONVERT = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 255;
    localparam int WDOG_W      = 16;

endpackage

// File: rtl/adc_arbiter_rr_priority.sv
// Round-robin winner selection for the ADC arbiter. Purely combinational:
// the search starts one past the last owner and wraps at NREQ-1, so indices
// at or above NREQ can never be produced even when NREQ is not a power of two.
module rr_priority
    import adc_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_owner,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    // Scan candidates last_owner+1 .. last_owner+NREQ (mod NREQ), first hit wins.
    always_comb begin : pick
        int            cand;
        logic [IW-1:0] ci;
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = 0;
        ci     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_owner) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            ci = IW'(cand);
            if (!valid && req[ci]) begin
                winner[ci] = 1'b1;
                idx        = ci;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_arbiter.sv
// Arbiter granting one shared column ADC to NREQ row sequencers.
// Optional conversion watchdog is built only when ADC_ARBITER_TIMEOUT_EN is
// defined; otherwise timeout_err is tied low and CONVERT waits for adc_done.
//
// state   | meaning
// IDLE    | no owner; pick round-robin winner when any req is set
// START   | grant registered; raise adc_enable
// CONVERT | conversion running; wait for adc_done (or watchdog abort)
// RELEASE | one-cycle ADC settle gap before the next arbitration
module adc_arbiter
    import adc_arb_pkg::*;
#(
    parameter  int NREQ    = NREQ_DEF,
    parameter  int TIMEOUT = TIMEOUT_DEF,
    localparam int IW      = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            adc_enable,
    input  logic            adc_done,
    output logic [NREQ-1:0] ack,
    output logic            busy,
    output logic            timeout_err
);

    arb_state_t      state;
    logic [IW-1:0]   last_owner;
    logic [NREQ-1:0] rr_winner;
    logic [IW-1:0]   rr_idx;
    logic            rr_valid;

`ifdef ADC_ARBITER_TIMEOUT_EN
    // Counts completed CONVERT cycles; abort when the count would reach TIMEOUT.
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
    logic [WDOG_W-1:0] wdog;
`else
    assign timeout_err = 1'b0;
`endif

    rr_priority #(.NREQ(NREQ)) u_rr (
        .req        (req),
        .last_owner (last_owner),
        .winner     (rr_winner),
        .idx        (rr_idx),
        .valid      (rr_valid)
    );

    // Busy is derived straight from the state register.
    assign busy = (state != ST_IDLE);

    // Arbitration FSM with registered grant/enable/ack outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            grant_idx  <= '0;
            adc_enable <= 1'b0;
            ack        <= '0;
            // Last owner starts at NREQ-1 so requester 0 wins the first round.
            last_owner <= IW'(NREQ - 1);
`ifdef ADC_ARBITER_TIMEOUT_EN
            wdog        <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            ack <= '0;
`ifdef ADC_ARBITER_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (rr_valid) begin
                        grant     <= rr_winner;
                        grant_idx <= rr_idx;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    adc_enable <= 1'b1;
`ifdef ADC_ARBITER_TIMEOUT_EN
                    wdog       <= '0;
`endif
                    state      <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    // adc_done wins over a simultaneous watchdog expiry.
                    if (adc_done) begin
                        adc_enable <= 1'b0;
                        grant      <= '0;
                        ack        <= grant;
                        last_owner <= grant_idx;
                        state      <= ST_RELEASE;
                    end
`ifdef ADC_ARBITER_TIMEOUT_EN
                    else if (wdog == WDOG_LAST) begin
                        adc_enable  <= 1'b0;
                        grant       <= '0;
                        timeout_err <= 1'b1;
                        last_owner  <= grant_idx;
                        state       <= ST_RELEASE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
